// File: rtl/sum_acc_pkg.sv
// ============================================================================
// Module : sum_acc_pkg
// Shared types and sizing helpers for the frame accumulator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sum_acc_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DEF_DATA_W    = 4;
    localparam int DEF_FRAME_LEN = 8;

    // Smallest sum width that can hold FRAME_LEN full-scale samples.
    function automatic int acc_width(input int data_w, input int frame_len);
        return data_w + $clog2(frame_len);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dout_if.sv
// ============================================================================
// Module : dout_if
// Valid-qualified data bundle without back-pressure.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface dout_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] data;
    logic             valid;

    modport m (output data, output valid);
    modport s (input  data, input  valid);
endinterface

`default_nettype wire

// File: rtl/sum_acc.sv
// ============================================================================
// Module : sum_acc
// Sums FRAME_LEN valid samples per frame and emits a one-cycle result pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sum_acc
    import sum_acc_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int ACC_W     = acc_width(DATA_W, FRAME_LEN)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    dout_if.s    din,
    dout_if.m    acc,
    output logic busy
);

    localparam int              CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    state_e             state_q;
    logic [ACC_W-1:0]   sum_q;
    logic [ACC_W-1:0]   sum_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   acc_data_q;
    logic               acc_valid_q;
    logic               busy_q;
    logic               take;
    logic               last;

    always_comb begin
        take  = en & din.valid;
        last  = (cnt_q == CNT_LAST);
        sum_d = sum_q + ACC_W'(din.data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            cnt_q       <= '0;
            acc_data_q  <= '0;
            acc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            acc_valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: if (en)  state_q <= ST_RUN;
                ST_RUN:  if (!en) state_q <= ST_IDLE;
                default:          state_q <= ST_IDLE;
            endcase

            // Abort wins over a concurrent sample, including a frame-closing one.
            if (clr) begin
                sum_q  <= '0;
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end else if (take) begin
                if (last) begin
                    acc_data_q  <= sum_d;
                    acc_valid_q <= 1'b1;
                    sum_q       <= '0;
                    cnt_q       <= '0;
                    busy_q      <= 1'b0;
                end else begin
                    sum_q  <= sum_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    busy_q <= 1'b1;
                end
            end
        end
    end

    assign acc.data  = acc_data_q;
    assign acc.valid = acc_valid_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_sum_acc.sv
// ============================================================================
// Module : tb_sum_acc
// Directed and randomized checks of sum_acc against a frame-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sum_acc;

    localparam int DATA_W    = 4;
    localparam int FRAME_LEN = 4;
    localparam int ACC_W     = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en    = 1'b0;
    logic clr   = 1'b0;
    logic busy;

    dout_if #(.WIDTH(DATA_W)) din_if ();
    dout_if #(.WIDTH(ACC_W))  acc_if ();

    sum_acc #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .ACC_W     (ACC_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .din   (din_if),
        .acc   (acc_if),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cmp_on = 1'b0;

    // Model: the samples of the open frame, plus the last reported result.
    int               frame[$];
    logic             m_valid = 1'b0;
    logic [ACC_W-1:0] m_data  = '0;

    int pulse_data[$];
    int pulse_cyc[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame.delete();
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            m_valid = 1'b0;
            if (clr) begin
                frame.delete();
            end else if (en && din_if.valid) begin
                frame.push_back(int'(din_if.data));
                if (frame.size() == FRAME_LEN) begin
                    int s;
                    s = 0;
                    foreach (frame[i]) s += frame[i];
                    m_data  = s[ACC_W-1:0];
                    m_valid = 1'b1;
                    frame.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("acc_valid", int'(acc_if.valid), int'(m_valid));
            chk("acc_data",  int'(acc_if.data),  int'(m_data));
            chk("busy",      int'(busy),         (frame.size() != 0) ? 1 : 0);
            if (acc_if.valid) begin
                pulse_data.push_back(int'(acc_if.data));
                pulse_cyc.push_back(cyc);
            end
        end
    end

    task automatic step(input logic e, input logic v, input int d, input logic c);
        en           = e;
        din_if.valid = v;
        din_if.data  = DATA_W'(d);
        clr          = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 0, 1'b0);
    endtask

    function automatic int pulse_at(input int idx);
        if (idx < pulse_data.size()) return pulse_data[idx];
        return -1;
    endfunction

    initial begin
        din_if.valid = 1'b0;
        din_if.data  = '0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        cmp_on = 1'b1;
        chk("reset_valid", int'(acc_if.valid), 0);
        chk("reset_data",  int'(acc_if.data),  0);
        chk("reset_busy",  int'(busy),         0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Consecutive 1,2,3,4
        pulse_data.delete(); pulse_cyc.delete();
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, i, 1'b0);
        idle(3);
        chk("seq_count", pulse_data.size(), 1);
        chk("seq_sum",   pulse_at(0), 10);

        // Full-scale samples with random gaps
        pulse_data.delete(); pulse_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 15, 1'b0);
            if (i == 0) chk("gap_busy_first", int'(busy), 1);
            repeat ($urandom_range(0, 3)) step(1'b1, 1'b0, 0, 1'b0);
        end
        idle(3);
        chk("gap_count", pulse_data.size(), 1);
        chk("gap_sum",   pulse_at(0), 60);
        chk("gap_busy_after", int'(busy), 0);

        // Back-to-back frames
        pulse_data.delete(); pulse_cyc.delete();
        repeat (8) step(1'b1, 1'b1, 5, 1'b0);
        idle(2);
        chk("b2b_count", pulse_data.size(), 2);
        chk("b2b_sum0",  pulse_at(0), 20);
        chk("b2b_sum1",  pulse_at(1), 20);
        chk("b2b_gap",   (pulse_cyc.size() == 2) ? pulse_cyc[1] - pulse_cyc[0] : -1, 4);

        // Abort with a concurrent sample
        pulse_data.delete(); pulse_cyc.delete();
        step(1'b1, 1'b1, 3, 1'b0);
        step(1'b1, 1'b1, 3, 1'b0);
        step(1'b1, 1'b1, 3, 1'b1);
        chk("clr_busy", int'(busy), 0);
        repeat (4) step(1'b1, 1'b1, 1, 1'b0);
        idle(2);
        chk("clr_count", pulse_data.size(), 1);
        chk("clr_sum",   pulse_at(0), 4);

        // Pause mid-frame with valid samples offered
        pulse_data.delete(); pulse_cyc.delete();
        step(1'b1, 1'b1, 2, 1'b0);
        step(1'b1, 1'b1, 2, 1'b0);
        repeat (5) step(1'b0, 1'b1, 9, 1'b0);
        chk("pause_busy", int'(busy), 1);
        step(1'b1, 1'b1, 2, 1'b0);
        step(1'b1, 1'b1, 2, 1'b0);
        idle(2);
        chk("pause_count", pulse_data.size(), 1);
        chk("pause_sum",   pulse_at(0), 8);

        // Reset mid-frame
        pulse_data.delete(); pulse_cyc.delete();
        repeat (3) step(1'b1, 1'b1, 7, 1'b0);
        din_if.valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_busy",  int'(busy),         0);
        chk("async_data",  int'(acc_if.data),  0);
        chk("async_valid", int'(acc_if.valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_no_pulse", pulse_data.size(), 0);
        repeat (4) step(1'b1, 1'b1, 1, 1'b0);
        idle(2);
        chk("rst_count", pulse_data.size(), 1);
        chk("rst_sum",   pulse_at(0), 4);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                din_if.valid = 1'b0;
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end else begin
                step(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                     int'($urandom_range(0, 15)),
                     ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
            end
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sum_acc.md
SUM_ACC -- requirements
Module: sum_acc

Interface
REQ-001 Parameter DATA_W, default 4, width of each input sample; matches adder output width.
REQ-002 Parameter FRAME_LEN, default 8, number of valid samples per accumulation frame; legal range 2..256.
REQ-003 Parameter ACC_W, default DATA_W + $clog2(FRAME_LEN), output sum width; SHALL be >= DATA_W + $clog2(FRAME_LEN).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  accumulate enable; samples ignored while low.
REQ-007 clr  input  1  synchronous frame abort; discards the partial sum and count.
REQ-008 din  dout_if.s (DATA_W)  data/valid from the adder output stage; valid-only, no back-pressure.
REQ-009 acc  dout_if.m (ACC_W)  frame sum output; valid is a one-cycle pulse.
REQ-010 busy  output  1  high while a partial frame is held (count != 0).

Function
REQ-011 FSM states: IDLE (en low), RUN (en high); IDLE->RUN when en=1, RUN->IDLE when en=0.
REQ-012 In RUN, each cycle with din.valid=1 SHALL add zero-extended din.data to the accumulator and increment the sample counter.
REQ-013 Cycles with din.valid=0 SHALL leave the accumulator, counter and outputs unchanged (gaps allowed, any length).
REQ-014 On the FRAME_LEN-th accepted sample: acc.data <= accumulator + sample; acc.valid <= 1 on the next cycle; accumulator and counter return to 0 in the same edge.
REQ-015 Latency: acc.valid asserts exactly 1 cycle after the edge that samples the final input of a frame.
REQ-016 Back-to-back frames: a sample on the cycle after a frame close SHALL start the next frame with no lost sample.
REQ-017 acc.valid SHALL be high for exactly one cycle per completed frame; acc.data SHALL hold its last value until the next frame completes.
REQ-018 Sum arithmetic is unsigned and never overflows given REQ-003; no saturation logic.
REQ-019 clr=1 SHALL zero the accumulator and counter at the next edge and take priority over a simultaneous din.valid (that sample is dropped); acc.data and acc.valid are unaffected except that a completing frame on that cycle is also dropped.
REQ-020 en deasserted mid-frame: the partial sum and count are held, not cleared; accumulation resumes on return to RUN.
REQ-021 busy = (counter != 0), registered.

Reset
REQ-022 On rst_n=0: state=IDLE, accumulator=0, counter=0, acc.data=0, acc.valid=0, busy=0, immediately and independent of clk.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; no acc.valid pulse for it after release.
REQ-024 Reset release SHALL be synchronised to clk externally; first sample is accepted on the first edge after release with en=1.

Structure
REQ-025 The FSM state enum and an ACC_W helper function SHALL live in shared package sum_acc_pkg.
REQ-026 Single module; no sub-module is warranted (counter, adder and FSM are inline).
REQ-027 din and acc use the existing dout_if interface with the s and m modports respectively.

Verification (DATA_W=4, FRAME_LEN=4, ACC_W=6)
REQ-028 en=1; samples 1,2,3,4 on consecutive cycles -> single acc.valid pulse, acc.data=10, one cycle after sample 4.
REQ-029 Samples 15x4 with 0-3 idle cycles between them -> acc.data=60, one pulse, busy high from sample 1 until the frame closes.
REQ-030 Eight consecutive samples of 5 -> two pulses 4 cycles apart, each acc.data=20.
REQ-031 Samples 3,3, clr with valid=1 (data 3), then 1,1,1,1 -> one pulse, acc.data=4.
REQ-032 Samples 2,2, en=0 for 5 cycles with valid=1 (data 9), en=1, samples 2,2 -> acc.data=8.
REQ-033 Samples 7,7,7, rst_n low for 1 cycle, then samples 1,1,1,1 -> no pulse before reset; after reset one pulse with acc.data=4; all outputs 0 during reset.
